// File: rtl/skid_fifo_slice.sv
// Valid/ready skid buffer: DEPTH-entry in-order store with a register-only up_ready.
// MODE 0 forwards upstream straight through when empty; MODE 1 drives downstream only from storage.
module skid_fifo_slice #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2,
    parameter int MODE   = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DATA_W-1:0]          up_data,
    input  logic                       up_valid,
    output logic                       up_ready,
    output logic [DATA_W-1:0]          down_data,
    output logic                       down_valid,
    input  logic                       down_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic empty_s;
    logic up_ready_s;
    logic down_valid_s;
    logic accept_s;
    logic send_s;
    logic push_s;
    logic pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Handshake outputs; up_ready looks only at registered occupancy and rst.
    always_comb begin
        empty_s      = (count_q == {CNT_W{1'b0}});
        up_ready_s   = ~rst & (count_q != FULL_CNT);
        down_valid_s = 1'b0;
        down_data    = {DATA_W{1'b0}};
        if (rst) begin
            down_valid_s = 1'b0;
            down_data    = {DATA_W{1'b0}};
        end else if (MODE == 0) begin
            down_valid_s = ~empty_s | up_valid;
            down_data    = empty_s ? up_data : mem_q[rd_q];
        end else begin
            down_valid_s = ~empty_s;
            down_data    = mem_q[rd_q];
        end
        up_ready   = up_ready_s;
        down_valid = down_valid_s;
        count      = count_q;
    end

    // Push/pop decisions; in MODE 0 an empty buffer with a ready sink lets the beat fly through.
    always_comb begin
        accept_s = up_valid & up_ready_s;
        send_s   = down_valid_s & down_ready;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        if (MODE == 0) begin
            push_s = accept_s & ~(empty_s & down_ready);
            pop_s  = send_s & ~empty_s;
        end else begin
            push_s = accept_s;
            pop_s  = send_s;
        end
    end

    // Next-state for storage, pointers and occupancy.
    always_comb begin
        mem_d   = mem_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        count_d = count_q;
        if (push_s) begin
            mem_d[wr_q] = up_data;
            wr_d        = ptr_inc(wr_q);
        end else begin
            wr_d = wr_q;
        end
        if (pop_s) begin
            rd_d = ptr_inc(rd_q);
        end else begin
            rd_d = rd_q;
        end
        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; reset also scrubs the payload store so nothing stale can resurface.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q    <= {PTR_W{1'b0}};
            wr_q    <= {PTR_W{1'b0}};
            count_q <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_skid_fifo_slice.sv
// Directed and randomised-stall bench for skid_fifo_slice across several MODE/DEPTH configurations.
module tb_skid_fifo_slice;

    localparam int NB = 10000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] up_data = 8'h00;
    logic up_valid = 1'b0;
    logic down_ready = 1'b0;

    logic ur0, ur1, ur2, ur3;
    logic dv0, dv1, dv2, dv3;
    logic [7:0] dd0, dd1, dd2, dd3;
    logic [1:0] cnt0, cnt1, cnt3;
    logic [0:0] cnt2;

    logic [12:0] r_up_data [2];
    logic        r_up_valid [2];
    logic        r_down_ready [2];
    logic        r_up_ready [2];
    logic        r_dv [2];
    logic [12:0] r_dd [2];
    logic [2:0]  r_cnt [2];

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    skid_fifo_slice #(.DATA_W(8), .DEPTH(2), .MODE(0)) u0 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur0),
        .down_data(dd0), .down_valid(dv0), .down_ready(down_ready), .count(cnt0));
    skid_fifo_slice #(.DATA_W(8), .DEPTH(2), .MODE(1)) u1 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur1),
        .down_data(dd1), .down_valid(dv1), .down_ready(down_ready), .count(cnt1));
    skid_fifo_slice #(.DATA_W(8), .DEPTH(1), .MODE(1)) u2 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur2),
        .down_data(dd2), .down_valid(dv2), .down_ready(down_ready), .count(cnt2));
    skid_fifo_slice #(.DATA_W(8), .DEPTH(3), .MODE(1)) u3 (
        .clk(clk), .rst(rst), .up_data(up_data), .up_valid(up_valid), .up_ready(ur3),
        .down_data(dd3), .down_valid(dv3), .down_ready(down_ready), .count(cnt3));
    skid_fifo_slice #(.DATA_W(13), .DEPTH(5), .MODE(0)) u4 (
        .clk(clk), .rst(rst), .up_data(r_up_data[0]), .up_valid(r_up_valid[0]), .up_ready(r_up_ready[0]),
        .down_data(r_dd[0]), .down_valid(r_dv[0]), .down_ready(r_down_ready[0]), .count(r_cnt[0]));
    skid_fifo_slice #(.DATA_W(13), .DEPTH(5), .MODE(1)) u5 (
        .clk(clk), .rst(rst), .up_data(r_up_data[1]), .up_valid(r_up_valid[1]), .up_ready(r_up_ready[1]),
        .down_data(r_dd[1]), .down_valid(r_dv[1]), .down_ready(r_down_ready[1]), .count(r_cnt[1]));

    function automatic logic [12:0] pat(input int i, input int n);
        return 13'((n * 37) + (i * 1111) + 5);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        up_valid = 1'b0;
        up_data = 8'h00;
        down_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            r_up_valid[i] = 1'b0;
            r_up_data[i] = 13'h0;
            r_down_ready[i] = 1'b0;
        end
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        up_valid = 1'b1;
        up_data = 8'hFF;
        down_ready = 1'b1;
        rst = 1'b1;
        #1;
        tests_run++; if (ur0 !== 1'b0) begin tests_failed++; $display("FAIL reset_up_ready_m0: got %b expected 0", ur0); end
        tests_run++; if (dv0 !== 1'b0) begin tests_failed++; $display("FAIL reset_down_valid_m0: got %b expected 0", dv0); end
        tests_run++; if (dd0 !== 8'h00) begin tests_failed++; $display("FAIL reset_down_data_m0: got %h expected 00", dd0); end
        tests_run++; if (dv1 !== 1'b0) begin tests_failed++; $display("FAIL reset_down_valid_m1: got %b expected 0", dv1); end
        tests_run++; if (cnt1 !== 2'd0) begin tests_failed++; $display("FAIL reset_count_m1: got %0d expected 0", cnt1); end
        step();
        rst = 1'b0;
        up_valid = 1'b0;
        #1;
        tests_run++; if (ur0 !== 1'b1) begin tests_failed++; $display("FAIL post_reset_up_ready: got %b expected 1", ur0); end
        tests_run++; if (dv0 !== 1'b0) begin tests_failed++; $display("FAIL post_reset_down_valid: got %b expected 0", dv0); end
    endtask

    task automatic test_bypass();
        logic [7:0] beats [3];
        beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
        apply_reset();
        down_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            up_valid = 1'b1;
            up_data = beats[k];
            #1;
            tests_run++; if (dv0 !== 1'b1 || dd0 !== beats[k]) begin tests_failed++; $display("FAIL bypass_data[%0d]: got v=%b d=%h expected v=1 d=%h", k, dv0, dd0, beats[k]); end
            tests_run++; if (ur0 !== 1'b1 || cnt0 !== 2'd0) begin tests_failed++; $display("FAIL bypass_state[%0d]: got ready=%b count=%0d expected ready=1 count=0", k, ur0, cnt0); end
            step();
        end
        up_valid = 1'b0;
        #1;
        tests_run++; if (cnt0 !== 2'd0 || dv0 !== 1'b0) begin tests_failed++; $display("FAIL bypass_end: got count=%0d v=%b expected count=0 v=0", cnt0, dv0); end
    endtask

    task automatic test_skid();
        int src = 0;
        int rcv = 0;
        apply_reset();
        for (int k = 0; k < 20; k++) begin
            up_valid = (src < 5);
            up_data = 8'hA0 + 8'(src);
            down_ready = (k >= 3);
            #1;
            if (k == 0) begin
                tests_run++; if (ur0 !== 1'b1 || dv0 !== 1'b1 || dd0 !== 8'hA0 || cnt0 !== 2'd0) begin tests_failed++; $display("FAIL skid_c0: got r=%b v=%b d=%h c=%0d expected r=1 v=1 d=a0 c=0", ur0, dv0, dd0, cnt0); end
            end else if (k == 1) begin
                tests_run++; if (ur0 !== 1'b1 || dd0 !== 8'hA0 || cnt0 !== 2'd1) begin tests_failed++; $display("FAIL skid_c1: got r=%b d=%h c=%0d expected r=1 d=a0 c=1", ur0, dd0, cnt0); end
            end else if (k == 2 || k == 3) begin
                tests_run++; if (ur0 !== 1'b0 || dd0 !== 8'hA0 || cnt0 !== 2'd2) begin tests_failed++; $display("FAIL skid_full[%0d]: got r=%b d=%h c=%0d expected r=0 d=a0 c=2", k, ur0, dd0, cnt0); end
            end else if (k == 4) begin
                tests_run++; if (ur0 !== 1'b1 || cnt0 !== 2'd1) begin tests_failed++; $display("FAIL skid_c4: got r=%b c=%0d expected r=1 c=1", ur0, cnt0); end
            end else begin
                src = src;
            end
            if (dv0 && down_ready) begin
                tests_run++; if (dd0 !== 8'hA0 + 8'(rcv)) begin tests_failed++; $display("FAIL skid_order[%0d]: got %h expected %h", rcv, dd0, 8'hA0 + 8'(rcv)); end
                rcv++;
            end
            if (up_valid && ur0) src++;
            step();
        end
        tests_run++; if (rcv !== 5 || cnt0 !== 2'd0) begin tests_failed++; $display("FAIL skid_total: got rcv=%0d count=%0d expected rcv=5 count=0", rcv, cnt0); end
    endtask

    task automatic test_mode1_latency();
        int src = 0;
        apply_reset();
        down_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            up_valid = 1'b1;
            up_data = 8'hB0 + 8'(src);
            #1;
            tests_run++; if (dv1 !== (k != 0)) begin tests_failed++; $display("FAIL m1d2_valid[%0d]: got %b expected %b", k, dv1, (k != 0)); end
            if (k != 0) begin
                tests_run++; if (dd1 !== 8'hB0 + 8'(k - 1)) begin tests_failed++; $display("FAIL m1d2_data[%0d]: got %h expected %h", k, dd1, 8'hB0 + 8'(k - 1)); end
            end
            if (ur1) src++;
            step();
        end
        apply_reset();
        src = 0;
        down_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            up_valid = 1'b1;
            up_data = 8'hC0 + 8'(src);
            #1;
            tests_run++; if (dv2 !== 1'(k % 2) || ur2 !== ~1'(k % 2)) begin tests_failed++; $display("FAIL m1d1_toggle[%0d]: got v=%b r=%b expected v=%b", k, dv2, ur2, 1'(k % 2)); end
            if (k % 2 == 1) begin
                tests_run++; if (dd2 !== 8'hC0 + 8'(k / 2)) begin tests_failed++; $display("FAIL m1d1_data[%0d]: got %h expected %h", k, dd2, 8'hC0 + 8'(k / 2)); end
            end
            if (ur2) src++;
            step();
        end
    endtask

    task automatic test_full_wrap();
        int src = 0;
        int rcv = 0;
        apply_reset();
        for (int k = 0; k < 14; k++) begin
            up_valid = (src < 6);
            up_data = 8'hD0 + 8'(src);
            down_ready = (k >= 3);
            #1;
            if (k == 3) begin
                tests_run++; if (cnt3 !== 2'd3 || ur3 !== 1'b0 || dd3 !== 8'hD0) begin tests_failed++; $display("FAIL wrap_full: got c=%0d r=%b d=%h expected c=3 r=0 d=d0", cnt3, ur3, dd3); end
            end else if (k == 4) begin
                tests_run++; if (cnt3 !== 2'd2 || ur3 !== 1'b1) begin tests_failed++; $display("FAIL wrap_resume: got c=%0d r=%b expected c=2 r=1", cnt3, ur3); end
            end else begin
                src = src;
            end
            if (dv3 && down_ready) begin
                tests_run++; if (dd3 !== 8'hD0 + 8'(rcv)) begin tests_failed++; $display("FAIL wrap_order[%0d]: got %h expected %h", rcv, dd3, 8'hD0 + 8'(rcv)); end
                rcv++;
            end
            if (up_valid && ur3) src++;
            step();
        end
        tests_run++; if (rcv !== 6 || cnt3 !== 2'd0) begin tests_failed++; $display("FAIL wrap_total: got rcv=%0d count=%0d expected rcv=6 count=0", rcv, cnt3); end
    endtask

    task automatic test_reset_midstream();
        apply_reset();
        down_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            up_valid = 1'b1;
            up_data = 8'hE0 + 8'(k);
            step();
        end
        up_valid = 1'b1;
        up_data = 8'h77;
        #1;
        tests_run++; if (cnt0 !== 2'd2 || cnt1 !== 2'd2) begin tests_failed++; $display("FAIL mid_prefill: got c0=%0d c1=%0d expected 2 2", cnt0, cnt1); end
        rst = 1'b1;
        #1;
        tests_run++; if (ur0 !== 1'b0 || dv0 !== 1'b0 || cnt0 !== 2'd0 || dd0 !== 8'h00) begin tests_failed++; $display("FAIL mid_reset_m0: got r=%b v=%b c=%0d d=%h expected 0 0 0 00", ur0, dv0, cnt0, dd0); end
        tests_run++; if (ur1 !== 1'b0 || dv1 !== 1'b0 || cnt1 !== 2'd0) begin tests_failed++; $display("FAIL mid_reset_m1: got r=%b v=%b c=%0d expected 0 0 0", ur1, dv1, cnt1); end
        step();
        rst = 1'b0;
        up_valid = 1'b1;
        up_data = 8'h5A;
        down_ready = 1'b1;
        #1;
        tests_run++; if (dv0 !== 1'b1 || dd0 !== 8'h5A) begin tests_failed++; $display("FAIL mid_first_m0: got v=%b d=%h expected v=1 d=5a", dv0, dd0); end
        tests_run++; if (dv1 !== 1'b0) begin tests_failed++; $display("FAIL mid_empty_m1: got v=%b expected 0", dv1); end
        step();
        up_valid = 1'b0;
        #1;
        tests_run++; if (dv0 !== 1'b0 || cnt0 !== 2'd0) begin tests_failed++; $display("FAIL mid_no_stale_m0: got v=%b c=%0d expected 0 0", dv0, cnt0); end
        tests_run++; if (dv1 !== 1'b1 || dd1 !== 8'h5A) begin tests_failed++; $display("FAIL mid_first_m1: got v=%b d=%h expected v=1 d=5a", dv1, dd1); end
        step();
        #1;
        tests_run++; if (dv1 !== 1'b0 || cnt1 !== 2'd0) begin tests_failed++; $display("FAIL mid_no_stale_m1: got v=%b c=%0d expected 0 0", dv1, cnt1); end
    endtask

    task automatic test_random_stalls();
        int sent [2];
        int rcv [2];
        logic stall [2];
        logic [12:0] held [2];
        logic ur_save;
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            sent[i] = 0; rcv[i] = 0; stall[i] = 1'b0; held[i] = 13'h0;
        end
        for (int cyc = 0; cyc < 60000 && (rcv[0] < NB || rcv[1] < NB); cyc++) begin
            for (int i = 0; i < 2; i++) begin
                r_up_valid[i] = (sent[i] < NB) && ($urandom_range(0, 3) != 0);
                r_up_data[i] = r_up_valid[i] ? pat(i, sent[i]) : 13'($urandom);
                r_down_ready[i] = ($urandom_range(0, 3) != 0);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                ur_save = r_up_ready[i];
                r_down_ready[i] = ~r_down_ready[i];
                #1;
                tests_run++; if (r_up_ready[i] !== ur_save) begin tests_failed++; $display("FAIL rnd_ready_glitch[%0d]: got %b expected %b", i, r_up_ready[i], ur_save); end
                r_down_ready[i] = ~r_down_ready[i];
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                if (stall[i]) begin
                    tests_run++; if (r_dv[i] !== 1'b1 || r_dd[i] !== held[i]) begin tests_failed++; $display("FAIL rnd_hold[%0d]: got v=%b d=%h expected v=1 d=%h", i, r_dv[i], r_dd[i], held[i]); end
                end
                if (r_dv[i] && r_down_ready[i]) begin
                    tests_run++; if (r_dd[i] !== pat(i, rcv[i])) begin tests_failed++; $display("FAIL rnd_order[%0d] beat %0d: got %h expected %h", i, rcv[i], r_dd[i], pat(i, rcv[i])); end
                    rcv[i]++;
                end
                if (r_up_valid[i] && r_up_ready[i]) sent[i]++;
                stall[i] = r_dv[i] && !r_down_ready[i];
                held[i] = r_dd[i];
            end
            step();
        end
        for (int i = 0; i < 2; i++) begin
            tests_run++; if (rcv[i] !== NB || r_cnt[i] !== 3'd0) begin tests_failed++; $display("FAIL rnd_total[%0d]: got rcv=%0d count=%0d expected rcv=%0d count=0", i, rcv[i], r_cnt[i], NB); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_skid();
        test_mode1_latency();
        test_full_wrap();
        test_reset_midstream();
        test_random_stalls();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/skid_fifo_slice.md
# skid_fifo_slice

Parametrised handshake register slice and skid buffer for valid/ready streams: breaks the upstream ready path with a register-derived `up_ready`, buffers up to DEPTH beats in order, and optionally registers the downstream valid/data path as well. It sits between any two valid/ready stages in the pipeline and replaces the single-entry, 8-bit, bypass-only skid stage with one configurable block.

## Interface
- DATA_W, 8, payload width in bits (≥1)
- DEPTH, 2, buffer entries (≥1; non-power-of-two allowed)
- MODE, 0, 0 = bypass (empty buffer forwards upstream combinationally), 1 = registered (downstream driven only from storage)
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- up_data  input  DATA_W  upstream payload
- up_valid  input  1  upstream beat offered
- up_ready  output  1  block accepts a beat this cycle
- down_data  output  DATA_W  downstream payload
- down_valid  output  1  beat offered downstream
- down_ready  input  1  downstream accepts
- count  output  $clog2(DEPTH+1)  entries currently stored

## Operation
- Storage: DEPTH×DATA_W circular buffer, read pointer rd, write pointer wr, occupancy count; pointers wrap from DEPTH-1 to 0.
- up_ready = (count != DEPTH), forced 0 while rst high; a pure function of registers, never of up_valid/down_ready/up_data.
- Accept = up_valid & up_ready. Send = down_valid & down_ready.
- MODE 0:
  - down_valid = (count != 0) | up_valid; down_data = (count != 0) ? mem[rd] : up_data.
  - Bypass: count == 0 and Accept and down_ready → beat goes straight through, no state change.
  - Push (write mem[wr], wr++) on Accept unless bypass. Pop (rd++) on Send when count != 0.
- MODE 1:
  - down_valid = (count != 0); down_data = mem[rd]; no upstream-to-downstream combinational path.
  - Push on Accept; pop on Send.
- count_next = count + push - pop; simultaneous push and pop leave count unchanged and both pointers advance.
- Push when full cannot occur (up_ready = 0). A pop when full does not re-enable up_ready in the same cycle; the next beat is accepted in the following cycle.
- Ordering: strict FIFO; stored beats always leave before any bypassed beat, so MODE 0 never bypasses while count != 0.
- Payload is sampled only on Accept; down_data is stable while down_valid & ~down_ready.
- Reset (asynchronous, any time including mid-transfer):
  - count, rd and wr clear to 0; mem contents clear to 0; stored beats are discarded.
  - Outputs while rst is high: up_ready = 0, down_valid = 0, down_data = 0 (both modes).
  - Normal operation resumes on the first rising edge after rst deasserts.

## Timing
- MODE 0 latency: 0 cycles when empty and down_ready; otherwise a beat leaves one or more cycles after Accept.
- MODE 1 latency: exactly 1 cycle minimum (Accept at edge N → down_valid at N+1).
- Throughput with down_ready held 1: one beat per cycle in MODE 0 for any DEPTH. In MODE 1, DEPTH ≥ 2 gives one beat per cycle; DEPTH = 1 gives one beat every 2 cycles.
- Skid capacity: after down_ready drops, up to DEPTH further beats are accepted before up_ready falls. up_ready reflects count at the start of the cycle.
- count is registered and updates on the edge following push/pop.

## Test plan
- MODE 0, DEPTH 2, down_ready = 1, beats 0x11,0x22,0x33 on consecutive cycles → each appears on down_data in the same cycle; count stays 0; up_ready stays 1.
- MODE 0, DEPTH 2: stream 0xA0..0xA4 while down_ready = 0 from the cycle 0xA0 is offered → 0xA0,0xA1 stored, count = 2, up_ready = 0 next cycle. Raise down_ready → output is 0xA0,0xA1 then 0xA2.. in order; no loss, no duplication.
- MODE 1, DEPTH 2, continuous up_valid with down_ready = 1 → first down_valid one cycle after first Accept, then one beat per cycle; MODE 1, DEPTH 1 → down_valid toggles every other cycle.
- MODE 1, DEPTH 3: fill to count = 3, then assert up_valid and down_ready together → pop 1st beat, up_ready = 0 that cycle, push resumes the next cycle; wrap of wr from 2 to 0 preserves order.
- Assert rst with count = 2 mid-stream → immediately up_ready = 0, down_valid = 0, count = 0. After release, new beat 0x5A is the first delivered; no stale data emerges.
- Random valid/ready stalls, DATA_W = 13, DEPTH = 5, both modes, 10k beats → scoreboard matches in order; up_ready never depends combinationally on down_ready (checked by forcing down_ready glitches mid-cycle).
